// File: rtl/sram_boot_pkg.sv
// rtl/sram_boot_pkg.sv - shared types and constants for the SRAM boot loader
package sram_boot_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int CNT_W_DEF  = 16;
    localparam int HDR_BYTES  = 2;
    localparam int WORD_BYTES = 4;

    typedef enum logic [2:0] {
        ST_LEN0,
        ST_LEN1,
        ST_DATA,
        ST_WRITE,
        ST_DONE
    } boot_state_e;

endpackage

// File: rtl/sram_boot_loader_packer.sv
// rtl/sram_boot_loader_packer.sv - assembles four stream bytes into a little-endian word
module boot_word_packer
    import sram_boot_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_data_i,
    output logic [31:0] word_o,
    output logic        word_ready_o
);

    localparam logic [1:0] LAST_IDX = 2'(WORD_BYTES - 1);

    logic [1:0]  idx_q, idx_d;
    logic [31:0] word_q, word_d;

    always_comb begin
        idx_d  = idx_q;
        word_d = word_q;
        if (byte_valid_i) begin
            word_d[idx_q*8 +: 8] = byte_data_i;
            idx_d                = idx_q + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q  <= 2'd0;
            word_q <= 32'd0;
        end else begin
            idx_q  <= idx_d;
            word_q <= word_d;
        end
    end

    // Pulses on the acceptance of the last byte; the word register holds it from the next cycle.
    assign word_ready_o = byte_valid_i && (idx_q == LAST_IDX);
    assign word_o       = word_q;

endmodule

// File: rtl/sram_boot_loader.sv
// rtl/sram_boot_loader.sv - loads a length-prefixed byte stream into SRAM, then passes CPU traffic through
module sram_boot_loader
    import sram_boot_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        boot_skip,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        cpu_resetn,
    output logic        boot_done,
    input  logic        cpu_mem_valid,
    input  logic        cpu_mem_instr,
    input  logic [31:0] cpu_mem_addr,
    input  logic [31:0] cpu_mem_wdata,
    input  logic [3:0]  cpu_mem_wstrb,
    output logic [31:0] cpu_mem_rdata,
    output logic        cpu_mem_ready,
    output logic        mem_valid,
    output logic        mem_instr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    localparam logic [CNT_W-1:0]  CNT_ONE  = 1;
    localparam logic [ADDR_W-1:0] WIDX_ONE = 1;

    boot_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  written_q, written_d;
    logic [ADDR_W-1:0] widx_q, widx_d;
    logic              rx_ready_c;
    logic              data_accept;
    logic              word_ready;
    logic [31:0]       word;

    // Reset forces the FSM to LEN0 asynchronously; rx_ready must still read 0 while rst is held.
    assign rx_ready    = rx_ready_c && !rst;
    assign data_accept = rx_valid && rx_ready && (state_q == ST_DATA);

    boot_word_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .byte_valid_i (data_accept),
        .byte_data_i  (rx_data),
        .word_o       (word),
        .word_ready_o (word_ready)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        written_d     = written_q;
        widx_d        = widx_q;
        rx_ready_c    = 1'b0;
        cpu_resetn    = 1'b0;
        boot_done     = 1'b0;
        cpu_mem_rdata = 32'd0;
        cpu_mem_ready = 1'b0;
        mem_valid     = 1'b0;
        mem_instr     = 1'b0;
        mem_addr      = 32'd0;
        mem_wdata     = 32'd0;
        mem_wstrb     = 4'h0;

        case (state_q)
            ST_LEN0: begin
                if (boot_skip) begin
                    state_d = ST_DONE;
                end else begin
                    rx_ready_c = 1'b1;
                    if (rx_valid) begin
                        cnt_d[7:0] = rx_data;
                        state_d    = ST_LEN1;
                    end
                end
            end
            ST_LEN1: begin
                rx_ready_c = 1'b1;
                if (rx_valid) begin
                    cnt_d[15:8] = rx_data;
                    state_d     = (cnt_d == '0) ? ST_DONE : ST_DATA;
                end
            end
            ST_DATA: begin
                rx_ready_c = 1'b1;
                if (word_ready) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                mem_valid = 1'b1;
                mem_wstrb = 4'hF;
                mem_addr  = {{(32-ADDR_W){1'b0}}, widx_q};
                mem_wdata = word;
                if (mem_ready) begin
                    widx_d    = widx_q + WIDX_ONE;
                    written_d = written_q + CNT_ONE;
                    state_d   = (written_d == cnt_q) ? ST_DONE : ST_DATA;
                end
            end
            ST_DONE: begin
                cpu_resetn    = 1'b1;
                boot_done     = 1'b1;
                mem_valid     = cpu_mem_valid;
                mem_instr     = cpu_mem_instr;
                mem_addr      = cpu_mem_addr;
                mem_wdata     = cpu_mem_wdata;
                mem_wstrb     = cpu_mem_wstrb;
                cpu_mem_rdata = mem_rdata;
                cpu_mem_ready = mem_ready;
            end
            default: begin
                state_d = ST_LEN0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_LEN0;
            cnt_q     <= '0;
            written_q <= '0;
            widx_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            written_q <= written_d;
            widx_q    <= widx_d;
        end
    end

endmodule

// File: tb/tb_sram_boot_loader.sv
// tb/tb_sram_boot_loader.sv - directed bench with a write scoreboard for sram_boot_loader
module tb_sram_boot_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        boot_skip = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_ready;
    logic        cpu_resetn;
    logic        boot_done;
    logic        cpu_mem_valid = 1'b0;
    logic        cpu_mem_instr = 1'b0;
    logic [31:0] cpu_mem_addr = 32'd0;
    logic [31:0] cpu_mem_wdata = 32'd0;
    logic [3:0]  cpu_mem_wstrb = 4'h0;
    logic [31:0] cpu_mem_rdata;
    logic        cpu_mem_ready;
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        stall = 1'b0;

    int checks = 0;
    int errors = 0;
    int write_cnt = 0;
    int valid_seen = 0;
    logic [63:0] exp_q[$];
    logic [31:0] sram [0:1023];

    always #5 clk = ~clk;

    sram_boot_loader dut (
        .clk           (clk),
        .rst           (rst),
        .boot_skip     (boot_skip),
        .rx_valid      (rx_valid),
        .rx_data       (rx_data),
        .rx_ready      (rx_ready),
        .cpu_resetn    (cpu_resetn),
        .boot_done     (boot_done),
        .cpu_mem_valid (cpu_mem_valid),
        .cpu_mem_instr (cpu_mem_instr),
        .cpu_mem_addr  (cpu_mem_addr),
        .cpu_mem_wdata (cpu_mem_wdata),
        .cpu_mem_wstrb (cpu_mem_wstrb),
        .cpu_mem_rdata (cpu_mem_rdata),
        .cpu_mem_ready (cpu_mem_ready),
        .mem_valid     (mem_valid),
        .mem_instr     (mem_instr),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_wstrb     (mem_wstrb),
        .mem_rdata     (mem_rdata),
        .mem_ready     (mem_ready)
    );

    // SRAM adapter model: same-cycle ready unless stalled; reads return an address-tagged pattern.
    assign mem_ready = mem_valid && !stall;
    assign mem_rdata = {16'hCAFE, mem_addr[15:0]};

    always @(posedge clk) begin
        if (mem_valid && mem_ready) begin
            for (int b = 0; b < 4; b++)
                if (mem_wstrb[b]) sram[mem_addr[9:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && mem_valid && !boot_done) valid_seen++;
        if (!rst && mem_valid && mem_ready && !boot_done) begin
            write_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_write", {mem_addr, mem_wdata}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                check("write_addr_data", {mem_addr, mem_wdata}, exp_q.pop_front());
                check("write_wstrb", 64'(mem_wstrb), 64'hF);
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        rx_valid = 1'b0;
        cpu_mem_valid = 1'b0;
        stall = 1'b0;
        @(posedge clk); #1;
        check("rst_cpu_resetn", 64'(cpu_resetn), 64'd0);
        check("rst_rx_ready", 64'(rx_ready), 64'd0);
        check("rst_boot_done", 64'(boot_done), 64'd0);
        check("rst_mem_valid", 64'(mem_valid), 64'd0);
        rst = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        rx_data = b;
        rx_valid = 1'b1;
        @(negedge clk);
        while (!rx_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("rx_handshake", 64'(rx_ready), 64'd1);
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    initial begin
        int wc;
        int vs;
        logic [31:0] d;

        // Two-word stream.
        do_reset();
        exp_q.push_back({32'd0, 32'h44332211});
        exp_q.push_back({32'd1, 32'hDDCCBBAA});
        send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        check("t1_write_valid", 64'(mem_valid), 64'd1);
        check("t1_write_rx_ready", 64'(rx_ready), 64'd0);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
        check("t1_resetn_before", 64'(cpu_resetn), 64'd0);
        @(posedge clk); #1;
        check("t1_resetn_after", 64'(cpu_resetn), 64'd1);
        check("t1_boot_done", 64'(boot_done), 64'd1);
        check("t1_writes", 64'(write_cnt), 64'd2);

        // Zero-length header.
        do_reset();
        wc = write_cnt;
        vs = valid_seen;
        send_byte(8'h00);
        check("t2_done_early", 64'(boot_done), 64'd0);
        send_byte(8'h00);
        check("t2_boot_done", 64'(boot_done), 64'd1);
        check("t2_cpu_resetn", 64'(cpu_resetn), 64'd1);
        repeat (2) @(posedge clk);
        #1;
        check("t2_no_valid", 64'(valid_seen - vs), 64'd0);
        check("t2_no_writes", 64'(write_cnt - wc), 64'd0);

        // boot_skip, CPU pass-through, rx ignored.
        boot_skip = 1'b1;
        do_reset();
        rx_data = 8'h5A;
        rx_valid = 1'b1;
        check("t3_len0_rx_ready", 64'(rx_ready), 64'd0);
        @(posedge clk); #1;
        check("t3_boot_done", 64'(boot_done), 64'd1);
        check("t3_rx_ready", 64'(rx_ready), 64'd0);
        boot_skip = 1'b0;
        cpu_mem_valid = 1'b1;
        cpu_mem_instr = 1'b1;
        cpu_mem_addr = 32'd5;
        cpu_mem_wstrb = 4'h0;
        #1;
        check("t3_pt_addr", 64'(mem_addr), 64'd5);
        check("t3_pt_instr", 64'(mem_instr), 64'd1);
        check("t3_pt_rdata", 64'(cpu_mem_rdata), 64'hCAFE0005);
        check("t3_pt_ready", 64'(cpu_mem_ready), 64'd1);
        stall = 1'b1;
        #1;
        check("t3_pt_ready_low", 64'(cpu_mem_ready), 64'd0);
        stall = 1'b0;
        cpu_mem_valid = 1'b0;
        cpu_mem_instr = 1'b0;
        rx_valid = 1'b0;

        // Stalled WRITE.
        do_reset();
        exp_q.push_back({32'd0, 32'h04030201});
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
        stall = 1'b1;
        send_byte(8'h04);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("t4_hold", {mem_valid, mem_instr, mem_wstrb, mem_addr[9:0], 16'd0, rx_ready},
                  {1'b1, 1'b0, 4'hF, 10'd0, 16'd0, 1'b0});
            check("t4_hold_wdata", 64'(mem_wdata), 64'h04030201);
        end
        stall = 1'b0;
        @(posedge clk); #1;
        check("t4_boot_done", 64'(boot_done), 64'd1);

        // 1025 words: address wraps and the last word overwrites address 0.
        do_reset();
        wc = write_cnt;
        send_byte(8'h01); send_byte(8'h04);
        for (int i = 0; i < 1025; i++) begin
            d = 32'h1000_0000 + 32'(i);
            exp_q.push_back({32'(i % 1024), d});
            for (int b = 0; b < 4; b++) send_byte(d[8*b +: 8]);
            if (i == 1023) check("t5_not_done", 64'(boot_done), 64'd0);
        end
        @(posedge clk); #1;
        check("t5_boot_done", 64'(boot_done), 64'd1);
        check("t5_writes", 64'(write_cnt - wc), 64'd1025);
        check("t5_sram0", 64'(sram[0]), 64'h1000_0400);
        check("t5_sram1", 64'(sram[1]), 64'h1000_0001);

        // Reset mid-load, then a fresh one-word stream.
        do_reset();
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'hAA); send_byte(8'hBB);
        do_reset();
        exp_q.push_back({32'd0, 32'h88776655});
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h55); send_byte(8'h66); send_byte(8'h77);
        check("t6_resetn_mid", 64'(cpu_resetn), 64'd0);
        send_byte(8'h88);
        check("t6_resetn_write", 64'(cpu_resetn), 64'd0);
        @(posedge clk); #1;
        check("t6_resetn_after", 64'(cpu_resetn), 64'd1);
        check("t6_sram0", 64'(sram[0]), 64'h88776655);

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_boot_loader.md
# sram_boot_loader

Boot-time loader between the picorv32 memory bus and the 4×8-bit SRAM bus adapter. After reset it holds the CPU in reset and accepts a length-prefixed byte stream from a serial receiver. It packs the stream into 32-bit little-endian words and writes them into SRAM with full-word strobes. It then releases the CPU and becomes a transparent pass-through for CPU memory traffic.

## Interface
- ADDR_W, 10: SRAM word-address width; depth is 2^ADDR_W words.
- CNT_W, 16: width of the word-count header.
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- boot_skip  in  1  bypass loading; sampled in LEN0.
- rx_valid  in  1  byte available from receiver.
- rx_data  in  8  byte from receiver.
- rx_ready  out  1  byte accepted on cycles where rx_valid && rx_ready.
- cpu_resetn  out  1  active-low CPU reset; high only in DONE.
- boot_done  out  1  high only in DONE.
- cpu_mem_valid, cpu_mem_instr  in  1 each  CPU bus request.
- cpu_mem_addr, cpu_mem_wdata  in  32 each  CPU address and write data.
- cpu_mem_wstrb  in  4  CPU byte strobes.
- cpu_mem_rdata  out  32  read data returned to CPU.
- cpu_mem_ready  out  1  ready returned to CPU.
- mem_valid, mem_instr  out  1 each  request to the SRAM adapter.
- mem_addr, mem_wdata  out  32 each  SRAM address (word index in [ADDR_W-1:0]) and write data.
- mem_wstrb  out  4  SRAM byte strobes.
- mem_rdata  in  32  SRAM read data.
- mem_ready  in  1  SRAM ready; may be asserted in the same cycle as mem_valid.

## Operation
- States: LEN0, LEN1, DATA, WRITE, DONE. Reset state is LEN0.
- LEN0
  - If boot_skip=1, go to DONE. boot_skip has priority over rx_valid.
  - Otherwise, on an accepted byte: cnt[7:0] ← byte; go to LEN1.
- LEN1: on an accepted byte, cnt[15:8] ← byte.
  - If the full count is 0, go to DONE.
  - Otherwise go to DATA.
- DATA
  - Accepted byte k (k = 0..3) goes to word[8k+7:8k].
  - On the 4th byte, go to WRITE.
- WRITE
  - Drives mem_valid=1, mem_instr=0, mem_wstrb=4'hF, mem_addr={zeros, widx}, mem_wdata=word.
  - Holds these values until mem_ready=1.
  - On the ready cycle: widx ← widx+1 (mod 2^ADDR_W) and written ← written+1.
  - If written+1 == cnt, go to DONE; otherwise go to DATA.
- DONE is terminal until rst.
  - mem_* = cpu_mem_*, cpu_mem_rdata = mem_rdata, cpu_mem_ready = mem_ready (combinational pass-through).
  - rx_ready=0; stream bytes are ignored.
- rx_ready=1 only in LEN0, LEN1 and DATA. In LEN0 it is 0 while boot_skip=1.
- Outside DONE: cpu_mem_ready=0 and cpu_mem_rdata=0. The CPU bus is ignored.
- Count wrap-around: cnt > 2^ADDR_W is legal. widx wraps, so later words overwrite earlier ones. written is CNT_W bits and does not wrap before cnt.

## Timing
- Reset values: state=LEN0, cnt=0, widx=0, written=0, word=0.
- While rst=1 all outputs are 0, including rx_ready, so cpu_resetn=0.
- WRITE to DATA or DONE: WRITE lasts 1 cycle when mem_ready follows mem_valid combinationally, as in the current adapter.
  - mem_valid rises the cycle after the 4th byte is accepted.
- Throughput: at most one word per 5 cycles (4 accept cycles + 1 WRITE).
- cpu_resetn and boot_done rise the cycle after the final WRITE handshake, after LEN1 with count 0, or after LEN0 with boot_skip.
- rst asserted mid-load: immediate return to LEN0 and CPU held in reset. SRAM contents already written are kept, not cleared.
- No rx byte is accepted during WRITE, so back-pressure is guaranteed by rx_ready=0.

## Structure
- Package sram_boot_pkg holds:
  - state enum boot_state_e;
  - localparams HDR_BYTES=2 and WORD_BYTES=4;
  - default ADDR_W and CNT_W.
- One sub-module is natural: boot_word_packer, containing the byte index counter and the 32-bit little-endian shift/assembly register, with a word_ready pulse.
- FSM, counters and bus mux live in the top level.

## Test plan
- Stream 02 00 11 22 33 44 AA BB CC DD:
  - two writes: addr 0 = 32'h44332211, addr 1 = 32'hDDCCBBAA, wstrb 4'hF;
  - cpu_resetn rises the cycle after the 2nd handshake.
- Header 00 00: no mem_valid at any time; boot_done=1 the cycle after the 2nd byte.
- boot_skip=1 at reset release: DONE after 1 cycle.
  - A CPU read at addr 5 passes through unchanged with cpu_mem_ready=mem_ready.
  - A byte presented on rx is not accepted.
- Stall mem_ready low for 3 cycles in WRITE: mem_* held stable and rx_ready=0 throughout.
- Count 1025 with ADDR_W=10: the 1025th word is written to addr 0; DONE after 1025 writes.
- Assert rst after 2 of 4 data bytes, then send a new stream 01 00 + 4 bytes: the word is written to addr 0 with only the new bytes; cpu_resetn is 0 until completion.
